// File: rtl/trigger_sequencer_if.sv
// Trigger word handshake between the queue manager (master) and the sequencer (slave).
// The sequencer only accepts a word at an edge where both valid and ready are high.
interface trigger_sequencer_if;
    logic       trg_valid;
    logic [7:0] trg;
    logic       trg_ready;

    modport master (output trg_valid, output trg, input  trg_ready);
    modport slave  (input  trg_valid, input  trg, output trg_ready);
endinterface

// File: rtl/trigger_sequencer.sv
// Buffers 8-bit trigger words in a FIFO and plays them out as fixed-width pulses
// or counted idle waits, back-to-back with no gap between consecutive words.
module trigger_sequencer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int PULSE_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    trigger_sequencer_if.slave              trg_bus,
    output logic                            pulse,
    output logic [6:0]                      codeword,
    output logic                            busy,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [6:0] PULSE_LOAD = 7'(PULSE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

    state_t          state, state_nxt;
    logic [6:0]      counter, counter_nxt;
    logic [6:0]      codeword_q;
    logic            load_cw;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, push, pop;
    logic [7:0]      head;

    // Readiness comes from the registered count, so a pop at the same edge never frees a slot.
    assign full              = (count == CW'(FIFO_DEPTH));
    assign trg_bus.trg_ready = !full;
    assign push              = trg_bus.trg_valid && !full;
    assign head              = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= trg_bus.trg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (trg_bus.trg_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= '0;
            codeword_q <= '0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            if (load_cw) begin
                codeword_q <= head[6:0];
            end
        end
    end

    // A new word is decoded either from IDLE or on the last cycle of a pulse/wait,
    // which is what lets sequences run without a dead cycle between words.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        pop         = 1'b0;
        load_cw     = 1'b0;
        if (state == IDLE || counter == 7'd0) begin
            if (count != '0) begin
                pop = 1'b1;
                if (head[7]) begin
                    state_nxt   = PULSE;
                    counter_nxt = PULSE_LOAD;
                    load_cw     = 1'b1;
                end else if (head[6:0] != 7'd0) begin
                    state_nxt   = WAIT;
                    counter_nxt = head[6:0] - 7'd1;
                end else begin
                    state_nxt   = IDLE;
                end
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            counter_nxt = counter - 7'd1;
        end
    end

    assign pulse      = (state == PULSE);
    assign codeword   = codeword_q;
    assign busy       = (state != IDLE) || (count != '0);
    assign fifo_count = count;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: accepted words feed a queue of expected
// pulses (codeword plus low cycles before it), popped as the DUT produces each pulse.
module tb_trigger_sequencer;

    localparam int DEPTH = 8;
    localparam int PW    = 4;

    typedef struct {
        int cw;
        int gap;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       pulse;
    logic [6:0] codeword;
    logic       busy;
    logic       overflow;
    logic [3:0] fifoCount;

    trigger_sequencer_if trgIf ();

    trigger_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .PULSE_WIDTH(PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trg_bus   (trgIf),
        .pulse     (pulse),
        .codeword  (codeword),
        .busy      (busy),
        .overflow  (overflow),
        .fifo_count(fifoCount)
    );

    int   assertCount = 0;
    int   failCount   = 0;
    exp_t sbQueue[$];
    exp_t monItem;
    bit   monEn;
    int   run;
    int   lowRun;
    int   pending;
    int   lastCw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Model: pulse words become expected pulses; waits accumulate the low cycles before the next one.
    task automatic modelAccept(input logic [7:0] w);
        exp_t e;
        if (w[7]) begin
            e.cw  = int'(w[6:0]);
            e.gap = pending;
            sbQueue.push_back(e);
            pending = 0;
        end else begin
            pending += (w[6:0] == 7'd0) ? 1 : int'(w[6:0]);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] w, input bit expectAccept);
        trgIf.trg_valid = 1'b1;
        trgIf.trg       = w;
        if (monEn && expectAccept) modelAccept(w);
        @(posedge clk);
        #1;
    endtask

    task automatic endPush();
        trgIf.trg_valid = 1'b0;
        trgIf.trg       = 8'h00;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== 1'b0) checkOutput("idleTimeout", 1, 0);
        @(posedge clk);
        #1;
        pending = 1;
    endtask

    // Pulse runs are split every PW cycles so back-to-back pulse words are seen individually.
    always @(negedge clk) begin
        if (monEn) begin
            if (pulse === 1'b1) begin
                if (run == 0 || run == PW) begin
                    if (sbQueue.size() == 0) begin
                        checkOutput("unexpectedPulse", 1, 0);
                    end else begin
                        monItem = sbQueue.pop_front();
                        checkOutput("pulseCodeword", 32'(codeword), monItem.cw);
                        checkOutput("pulseGap", lowRun, monItem.gap);
                        lastCw = monItem.cw;
                    end
                    run    = 1;
                    lowRun = 0;
                end else begin
                    run++;
                    checkOutput("codewordHold", 32'(codeword), lastCw);
                end
            end else begin
                if (run != 0) begin
                    checkOutput("pulseLen", run, PW);
                    run = 0;
                end
                checkOutput("idleCodeword", 32'(codeword), lastCw);
                if (busy) lowRun++;
                else      lowRun = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        int seen;
        rst_n           = 1'b0;
        trgIf.trg_valid = 1'b0;
        trgIf.trg       = 8'h00;
        monEn           = 1'b0;
        run             = 0;
        lowRun          = 0;
        pending         = 1;
        lastCw          = 0;

        #2;
        checkOutput("rstPulse", pulse, 0);
        checkOutput("rstCodeword", 32'(codeword), 0);
        checkOutput("rstCount", 32'(fifoCount), 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstOverflow", overflow, 0);
        checkOutput("rstReady", trgIf.trg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        monEn = 1'b1;

        $display("[TB] single pulse");
        applyStimulus(8'h85, 1);
        endPush();
        checkOutput("countAfterPush", 32'(fifoCount), 1);
        waitIdle(40);
        checkOutput("busyAfterSingle", busy, 0);
        checkOutput("codewordAfterSingle", 32'(codeword), 5);

        $display("[TB] pulse-wait-pulse");
        applyStimulus(8'h81, 1);
        applyStimulus(8'h03, 1);
        applyStimulus(8'h82, 1);
        endPush();
        waitIdle(60);

        $display("[TB] wait-0 between pulses, then back-to-back pulses");
        applyStimulus(8'h8A, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h8B, 1);
        endPush();
        waitIdle(60);
        applyStimulus(8'h8A, 1);
        applyStimulus(8'h8B, 1);
        endPush();
        waitIdle(60);

        $display("[TB] overflow");
        applyStimulus(8'h7F, 1);
        endPush();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(8'h80 + 8'(i), 1);
        end
        checkOutput("readyWhenFull", trgIf.trg_ready, 0);
        applyStimulus(8'hFF, 0);
        endPush();
        checkOutput("countWhenFull", 32'(fifoCount), DEPTH);
        checkOutput("overflowSet", overflow, 1);
        waitIdle(300);
        checkOutput("overflowSticky", overflow, 1);
        checkOutput("countDrained", 32'(fifoCount), 0);

        $display("[TB] async reset mid-pulse");
        monEn = 1'b0;
        applyStimulus(8'h90, 1);
        applyStimulus(8'h91, 1);
        applyStimulus(8'h92, 1);
        endPush();
        seen = 0;
        while (pulse !== 1'b1 && seen < 10) begin
            @(posedge clk);
            #1;
            seen++;
        end
        @(posedge clk);
        #3;
        checkOutput("pulseBeforeReset", pulse, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstPulse", pulse, 0);
        checkOutput("asyncRstCodeword", 32'(codeword), 0);
        checkOutput("asyncRstCount", 32'(fifoCount), 0);
        checkOutput("asyncRstBusy", busy, 0);
        checkOutput("asyncRstOverflow", overflow, 0);
        checkOutput("asyncRstReady", trgIf.trg_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("postRstPulse", pulse, 0);
        checkOutput("postRstBusy", busy, 0);
        checkOutput("postRstCount", 32'(fifoCount), 0);
        sbQueue.delete();
        run     = 0;
        lowRun  = 0;
        lastCw  = 0;
        pending = 1;
        monEn   = 1'b1;

        $display("[TB] max wait");
        applyStimulus(8'h7F, 1);
        applyStimulus(8'h81, 1);
        endPush();
        waitIdle(200);

        checkOutput("scoreboardDrained", sbQueue.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Consumer end of the queue-manager trigger stream. Accepts 8-bit trigger words (`trg[7]` = 1 pulse, 0 wait; `trg[6:0]` = codeword or wait length), buffers them in a small FIFO, and plays them out in order. Pulse words drive a fixed-width `pulse` strobe with the codeword presented; wait words hold the output idle for a counted number of cycles. It sits between the queue manager and the analog/AWG trigger outputs.

## Interface

Parameters:
- `FIFO_DEPTH`, 8. Trigger FIFO entries; power of two, ≥ 2.
- `PULSE_WIDTH`, 4. Cycles `pulse` stays high per pulse word; legal range 1..127.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trg_valid`  in  1  `trg` holds a word to enqueue this cycle.
- `trg`  in  8  trigger word; [7] = pulse(1)/wait(0), [6:0] = codeword or wait count.
- `trg_ready`  out  1  FIFO not full; combinational from registered count.
- `pulse`  out  1  trigger strobe.
- `codeword`  out  7  codeword of the current or most recent pulse word.
- `busy`  out  1  FSM not IDLE, or FIFO non-empty.
- `overflow`  out  1  sticky: a word was offered while the FIFO was full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation

- Reset, asserted asynchronously: FIFO emptied, FSM → IDLE. `pulse`=0, `codeword`=0, `overflow`=0, `fifo_count`=0, `busy`=0, `trg_ready`=1.
- Enqueue: a word is written at an edge where `trg_valid && trg_ready`.
  - With `trg_valid` high and FIFO full, the word is dropped and `overflow` is set.
  - `overflow` clears only on reset.
  - A pop in the same cycle does not make room; `trg_ready` reflects the pre-edge count.
- Simultaneous push and pop in a non-full, non-empty FIFO leaves `fifo_count` unchanged.
- FSM states: IDLE, PULSE, WAIT.
  - IDLE, FIFO non-empty: pop the head at this edge and decode it.
  - Pulse word: → PULSE. Load `codeword` = word[6:0], set `pulse`=1, counter = PULSE_WIDTH−1.
  - Wait word, N = word[6:0] > 0: → WAIT, counter = N−1, `pulse`=0.
  - Wait word, N = 0: no-op. Stay IDLE; the next pop is allowed at the following edge.
  - PULSE/WAIT, counter > 0: decrement the counter.
  - PULSE/WAIT, counter = 0 (last cycle), FIFO non-empty: pop and decode the next word at this same edge, so sequences run back-to-back with no gap.
  - PULSE/WAIT, counter = 0, FIFO empty: → IDLE and `pulse`=0.
- `codeword` holds its last value after a pulse ends and through waits. It changes only when a pulse word is decoded.
- Consecutive pulse words with no wait between them give a continuously high `pulse` for k·PULSE_WIDTH cycles, with `codeword` updating at each boundary.
- Wait count arithmetic is unsigned 7-bit. Maximum wait is 127 cycles.

## Timing

- Word accepted at edge k into an empty FIFO, FSM IDLE: popped at edge k+1. `pulse` is high from edge k+1 through edge k+1+PULSE_WIDTH, i.e. PULSE_WIDTH cycles.
- `fifo_count` updates at the accept edge. `trg_ready` falls in the cycle after the edge that fills the FIFO.
- Wait N: output idle for exactly N cycles after its decode edge, then the next word decodes.
- Each wait-0 word costs one cycle in IDLE.
- `busy` is registered-state based. It falls in the first cycle where the FSM is IDLE and `fifo_count`=0.
- Reset mid-PULSE or mid-WAIT: `pulse` drops immediately (async), and queued words are discarded.

## Test plan

- **Single pulse:** reset, push `trg`=0x85 at edge 1 → `pulse` high edges 2..5 (PULSE_WIDTH=4), `codeword`=0x05; then `busy`=0.
- **Pulse–wait–pulse:** push 0x81, 0x03, 0x82 on consecutive cycles → pulse 4 cycles (cw 1), low exactly 3 cycles, pulse 4 cycles (cw 2). `codeword` stays 1 during the wait.
- **Back-to-back pulses and wait-0:** push 0x8A, 0x00, 0x8B → 4 cycles high, 1 cycle low, 4 cycles high. Pushing 0x8A, 0x8B directly → 8 contiguous high cycles, `codeword` changes from 0x0A to 0x0B at the boundary.
- **Overflow:** hold FSM in WAIT via 0x7F, push FIFO_DEPTH+1 words → `fifo_count`=8, `trg_ready`=0, extra word dropped, `overflow`=1. After draining, `overflow` is still 1.
- **Async reset mid-pulse:** push 0x90, assert `rst_n`=0 during cycle 2 of the pulse → `pulse`, `codeword`, `fifo_count`, `busy` go to 0 without a clock edge. After release, outputs stay idle.
- **Max wait:** push 0x7F then 0x81 → `pulse` rises exactly 127 cycles after the wait word's decode edge.
